// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard and sequencing controller for the 5-stage RV32I core.
//   Produces per-stage stall/flush enables for the IF/ID, ID/EX, EX/MEM and
//   MEM/WB pipeline registers, the execute-stage forwarding selects, a
//   data-memory timeout pulse and a saturating stall-cycle counter.
//
//   Compile-time option:
//     FORWARDING_EN  defined   -> forwarding unit active, only load-use stalls
//                    undefined -> fwd selects tied to 00, RAW on E/M producers
//                                 stalls decode until the producer leaves M
//
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     rs1D, rs2D                 decode-stage source registers
//     rs1E, rs2E                 execute-stage source registers
//     rdE, rdM, rdW              destination registers in E/M/W
//     reg_wrE, reg_wrM, reg_wrW  register-write enables in E/M/W
//     wb_selE                    E writeback select (2'b10 = load)
//     br_takenE                  branch taken / jump resolved in E
//     dmem_reqM, dmem_readyM     data-memory request / completion in M
//     stallF..stallM             hold PC, IF/ID, ID/EX, EX/MEM
//     flushD, flushE, flushW     bubble into IF/ID, ID/EX, MEM/WB
//     fwd_aE, fwd_bE             00 regfile, 01 from W, 10 from M
//     mem_err                    one-cycle pulse on memory timeout
//     stall_cycles               saturating count of cycles with stallF=1
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             rs1D,
    input  logic [4:0]             rs2D,
    input  logic [4:0]             rs1E,
    input  logic [4:0]             rs2E,
    input  logic [4:0]             rdE,
    input  logic [4:0]             rdM,
    input  logic [4:0]             rdW,
    input  logic                   reg_wrE,
    input  logic                   reg_wrM,
    input  logic                   reg_wrW,
    input  logic [1:0]             wb_selE,
    input  logic                   br_takenE,
    input  logic                   dmem_reqM,
    input  logic                   dmem_readyM,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   stallE,
    output logic                   stallM,
    output logic                   flushD,
    output logic                   flushE,
    output logic                   flushW,
    output logic [1:0]             fwd_aE,
    output logic [1:0]             fwd_bE,
    output logic                   mem_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_e;

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic load_use;
    logic data_hazard;
    logic freeze;     // memory wait: hold F..M, bubble into WB
    logic pipe_ctrl;  // branch / data-hazard logic may act this cycle
    logic timeout_pulse;

    logic       stallF_c, stallD_c, stallE_c, stallM_c;
    logic       flushD_c, flushE_c, flushW_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    // ------------------------------------------------------------------
    // Hazard detection (x0 never matches)
    // ------------------------------------------------------------------
    function automatic logic reads_reg(input logic [4:0] rd);
        return (rd != 5'd0) && ((rd == rs1D) || (rd == rs2D));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0) begin
            if (reg_wrM && (rdM == rs))      sel = 2'b10;
            else if (reg_wrW && (rdW == rs)) sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        load_use = (wb_selE == 2'b10) && reg_wrE && reads_reg(rdE);
`ifdef FORWARDING_EN
        data_hazard = load_use;
        fwd_a_c     = fwd_sel(rs1E);
        fwd_b_c     = fwd_sel(rs2E);
`else
        // Without bypassing, any in-flight producer in E or M blocks decode;
        // W needs no stall because the register file is write-first.
        data_hazard = (reg_wrE && reads_reg(rdE)) || (reg_wrM && reads_reg(rdM));
        fwd_a_c     = 2'b00;
        fwd_b_c     = 2'b00;
`endif
    end

    // ------------------------------------------------------------------
    // Sequencing FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        freeze        = 1'b0;
        pipe_ctrl     = 1'b0;
        timeout_pulse = 1'b0;

        case (state_q)
            RUN: begin
                if (dmem_reqM && !dmem_readyM) begin
                    freeze     = 1'b1;
                    wait_cnt_d = CNT_W'(1);
                    state_d    = (LAST_CNT == CNT_W'(1)) ? TIMEOUT : MEM_WAIT;
                end else begin
                    pipe_ctrl  = 1'b1;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (!dmem_readyM) begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    // wait_cnt counts stalled cycles including this one
                    if (wait_cnt_q + CNT_W'(1) == LAST_CNT) state_d = TIMEOUT;
                end else begin
                    // Release cycle behaves as RUN without a memory wait
                    pipe_ctrl  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = RUN;
                end
            end
            TIMEOUT: begin
                timeout_pulse = 1'b1;
                wait_cnt_d    = '0;
                state_d       = RUN;
            end
            default: begin
                wait_cnt_d = '0;
                state_d    = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stall / flush outputs by priority: memory wait, branch, data hazard
    // ------------------------------------------------------------------
    always_comb begin
        stallF_c = 1'b0;
        stallD_c = 1'b0;
        stallE_c = 1'b0;
        stallM_c = 1'b0;
        flushD_c = 1'b0;
        flushE_c = 1'b0;
        flushW_c = 1'b0;
        if (freeze) begin
            stallF_c = 1'b1;
            stallD_c = 1'b1;
            stallE_c = 1'b1;
            stallM_c = 1'b1;
            flushW_c = 1'b1;
        end else if (pipe_ctrl) begin
            if (br_takenE) begin
                flushD_c = 1'b1;
                flushE_c = 1'b1;
            end else if (data_hazard) begin
                stallF_c = 1'b1;
                stallD_c = 1'b1;
                flushE_c = 1'b1;
            end
        end
    end

    // Outputs are forced low while reset is asserted
    always_comb begin
        stallF       = rst_n & stallF_c;
        stallD       = rst_n & stallD_c;
        stallE       = rst_n & stallE_c;
        stallM       = rst_n & stallM_c;
        flushD       = rst_n & flushD_c;
        flushE       = rst_n & flushE_c;
        flushW       = rst_n & flushW_c;
        fwd_aE       = rst_n ? fwd_a_c : 2'b00;
        fwd_bE       = rst_n ? fwd_b_c : 2'b00;
        mem_err      = rst_n & timeout_pulse;
        stall_cycles = stall_cycles_q;
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stallF && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed and randomized checks of hazard_ctrl against a behavioural model.
//   Counter width is reduced to 4 bits so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int unsigned TO  = 16;
    localparam int unsigned SCW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [4:0]     rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic           reg_wrE, reg_wrM, reg_wrW;
    logic [1:0]     wb_selE;
    logic           br_takenE, dmem_reqM, dmem_readyM;
    logic           stallF, stallD, stallE, stallM;
    logic           flushD, flushE, flushW;
    logic [1:0]     fwd_aE, fwd_bE;
    logic           mem_err;
    logic [SCW-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    // model state
    bit m_wait, m_timeout;
    int m_cnt, m_stalls;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW),
        .reg_wrE(reg_wrE), .reg_wrM(reg_wrM), .reg_wrW(reg_wrW),
        .wb_selE(wb_selE), .br_takenE(br_takenE),
        .dmem_reqM(dmem_reqM), .dmem_readyM(dmem_readyM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .fwd_aE(fwd_aE), .fwd_bE(fwd_bE),
        .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit dep(input logic [4:0] rd);
        return rd != 0 && (rd == rs1D || rd == rs2D);
    endfunction

    function automatic bit hazard_now();
`ifdef FORWARDING_EN
        return wb_selE == 2'b10 && reg_wrE && dep(rdE);
`else
        return (reg_wrE && dep(rdE)) || (reg_wrM && dep(rdM));
`endif
    endfunction

    function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
`ifdef FORWARDING_EN
        if (rs == 0) return 2'b00;
        if (reg_wrM && rdM == rs) return 2'b10;
        if (reg_wrW && rdW == rs) return 2'b01;
`endif
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_timeout = 0; m_cnt = 0; m_stalls = 0;
    endtask

    task automatic idle();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        reg_wrE = 0; reg_wrM = 0; reg_wrW = 0; wb_selE = 0;
        br_takenE = 0; dmem_reqM = 0; dmem_readyM = 0;
    endtask

    // One cycle: check outputs mid-cycle against the model, then advance.
    task automatic step();
        bit sF, sD, sE, sM, fD, fE, fW, err, blocked;
        sF = 0; sD = 0; sE = 0; sM = 0; fD = 0; fE = 0; fW = 0; err = 0;
        @(negedge clk);
        if (m_timeout) begin
            err = 1; m_timeout = 0; m_wait = 0; m_cnt = 0;
        end else begin
            blocked = m_wait ? !dmem_readyM : (dmem_reqM && !dmem_readyM);
            if (blocked) begin
                {sF, sD, sE, sM, fW} = '1;
                m_cnt++;
                m_wait = 1;
                if (m_cnt == TO - 1) begin m_wait = 0; m_timeout = 1; end
            end else begin
                m_wait = 0; m_cnt = 0;
                if (br_takenE) begin fD = 1; fE = 1; end
                else if (hazard_now()) begin sF = 1; sD = 1; fE = 1; end
            end
        end
        chk("ctrl", 32'({stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_err}),
                    32'({sF, sD, sE, sM, fD, fE, fW, err}));
        chk("fwd", 32'({fwd_aE, fwd_bE}), 32'({fwd_exp(rs1E), fwd_exp(rs2E)}));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
        if (sF && m_stalls < (1 << SCW) - 1) m_stalls++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_stall, n_err;
        idle();
        model_reset();
        rst_n = 0;
        #2;
        chk("reset_ctrl", 32'({stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_err}), 32'd0);
        chk("reset_cnt", 32'(stall_cycles), 32'd0);
        #10 rst_n = 1;
        @(posedge clk); #1;

        // memory wait: 3 stalled cycles then ready
        dmem_reqM = 1; dmem_readyM = 0;
        repeat (3) step();
        dmem_readyM = 1;
        step();
        idle();
        chk("memwait_cnt", 32'(stall_cycles), 32'd3);

        // load-use on rs1D, then the same producer leaves for M
        wb_selE = 2'b10; reg_wrE = 1; rdE = 5; rs1D = 5;
        step();
        idle(); rdM = 5; reg_wrM = 1; rs1D = 5;
        step();
        idle();
        step();

        // forwarding selects
        reg_wrM = 1; rdM = 7; reg_wrW = 1; rdW = 7; rs1E = 7; rs2E = 7;
        step();
        rdM = 0; step();
        rs1E = 0; step();
        idle();

        // branch beats load-use
        wb_selE = 2'b10; reg_wrE = 1; rdE = 9; rs2D = 9; br_takenE = 1;
        step();
        // same case during MEM_WAIT: no flush until release
        dmem_reqM = 1; dmem_readyM = 0;
        repeat (3) step();
        dmem_readyM = 1;
        step();
        idle();
        step();

        // timeout: 15 stalled cycles then one mem_err cycle
        dmem_reqM = 1; dmem_readyM = 0;
        n_stall = 0; n_err = 0;
        repeat (TO) begin
            step();
            if (stallF) n_stall++;
            if (mem_err) n_err++;
        end
        idle();
        step();
        if (mem_err) n_err++;
        chk("timeout_stalls", 32'(n_stall), 32'd15);
        chk("timeout_err", 32'(n_err), 32'd1);

        // reset in the middle of a memory wait
        dmem_reqM = 1; dmem_readyM = 0;
        repeat (4) step();
        rst_n = 0;
        #1;
        chk("rst_mid_ctrl", 32'({stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_err}), 32'd0);
        chk("rst_mid_cnt", 32'(stall_cycles), 32'd0);
        idle();
        model_reset();
        #1 rst_n = 1;
        step();
        dmem_reqM = 1; dmem_readyM = 1;
        step();
        idle();

        // randomized traffic
        repeat (400) begin
            rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
            rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
            rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
            rdW  = 5'($urandom_range(0, 3));
            reg_wrE = 1'($urandom); reg_wrM = 1'($urandom); reg_wrW = 1'($urandom);
            wb_selE = 2'($urandom);
            br_takenE   = ($urandom_range(0, 5) == 0);
            dmem_reqM   = ($urandom_range(0, 2) == 0);
            dmem_readyM = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32I core. Watches the decode, execute, memory and writeback register addresses and the data-memory handshake. Drives per-stage stall and flush enables into the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the execute-stage forwarding selects. Handles load-use bubbles, taken-branch/jump squashes, and multi-cycle data-memory waits with a timeout.

## Interface
- MEM_TIMEOUT, 16: maximum cycles spent in MEM_WAIT before forced release (≥2)
- STALL_CNT_W, 32: width of the stall-cycle performance counter
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rs1D, rs2D  in  5 each  source registers of the instruction in decode
- rs1E, rs2E  in  5 each  source registers of the instruction in execute
- rdE, rdM, rdW  in  5 each  destination registers in E, M, W
- reg_wrE, reg_wrM, reg_wrW  in  1 each  register-write enables in E, M, W
- wb_selE  in  2  writeback select in E; 2'b10 = load
- br_takenE  in  1  branch taken or jump resolved in E
- dmem_reqM  in  1  M-stage instruction accesses data memory
- dmem_readyM  in  1  data memory completes the access this cycle
- stallF, stallD, stallE, stallM  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM
- flushD, flushE, flushW  out  1 each  load bubble into IF-ID / ID-EX / MEM-WB next edge
- fwd_aE, fwd_bE  out  2 each  operand select: 00 regfile, 01 from W, 10 from M
- mem_err  out  1  one-cycle pulse on memory timeout
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with stallF=1

## Operation
- States: RUN, MEM_WAIT, TIMEOUT. Reset → RUN. wait_cnt = 0. stall_cycles = 0. All outputs 0.
- Register index 0 never matches in any hazard or forward comparison.
- Priority, highest first: memory wait, branch flush, load-use/RAW stall.
- RUN with dmem_reqM && !dmem_readyM:
  - stallF, stallD, stallE, stallM = 1; flushW = 1.
  - Next state MEM_WAIT; wait_cnt = 1.
- MEM_WAIT:
  - Same outputs as above while dmem_readyM = 0; wait_cnt increments.
  - dmem_readyM = 1: all stalls 0 that cycle; next state RUN.
  - wait_cnt == MEM_TIMEOUT−1 without ready: next state TIMEOUT.
- TIMEOUT: stalls 0, mem_err = 1, access treated as complete; next state RUN.
- br_takenE in RUN with no memory wait:
  - flushD = flushE = 1; no stalls.
  - Any load-use in D is squashed with it.
- In MEM_WAIT, br_takenE is ignored; it is evaluated in the release cycle (RUN priority applies).
- Load-use, in RUN with no branch and no memory wait:
  - Condition: wb_selE==2'b10 && reg_wrE && rdE∈{rs1D,rs2D}.
  - Response: stallF = stallD = 1, flushE = 1, for exactly one cycle.
- Forwarding, when compiled in (see Configuration):
  - fwd_aE = 10 if reg_wrM && rdM==rs1E.
  - Else 01 if reg_wrW && rdW==rs1E.
  - Else 00.
  - fwd_bE uses rs2E with the same rules; M wins over W.
- stall_cycles increments by 1 every cycle with stallF = 1 and saturates at all-ones.

## Timing
- RUN outputs are combinational from inputs; they take effect at the next rising edge of the pipeline registers.
- State, wait_cnt and stall_cycles are registered.
- rst_n low clears state immediately, regardless of clock, including mid-MEM_WAIT. Outputs are 0 while rst_n is low.
- Load-use costs 1 bubble cycle. Taken branch costs 2 squashed instructions. A memory access with N wait cycles costs N stall cycles.
- Maximum freeze is MEM_TIMEOUT−1 cycles, followed by one TIMEOUT cycle.

## Configuration
- FORWARDING_EN defined: forwarding unit active as above; only load-use stalls are generated.
- FORWARDING_EN undefined:
  - fwd_aE = fwd_bE = 00.
  - Any RAW with rs1D/rs2D matching rdE (reg_wrE) or rdM (reg_wrM) gives stallF = stallD = 1, flushE = 1.
  - The stall repeats each cycle until the producer leaves M; the register file is write-first for W.

## Test plan
- Load-use: lw x5 in E (wb_selE=10, rdE=5), rs1D=5 → one cycle of stallF=stallD=flushE=1; next cycle stalls 0.
- Forwarding (FORWARDING_EN): rdM=7, reg_wrM=1, rdW=7, reg_wrW=1, rs1E=7 → fwd_aE=10. With rdM=0 → fwd_aE=01. With rs1E=0 → fwd_aE=00.
- Memory wait: dmem_reqM=1 with dmem_readyM=0 for 3 cycles, then 1 → stallF..stallM=1 for 3 cycles, 0 on the ready cycle; stall_cycles +3.
- Timeout (MEM_TIMEOUT=16): dmem_readyM held 0 → mem_err pulses exactly one cycle after 15 stalled cycles; then RUN.
- Branch vs load-use: br_takenE=1 with a load-use condition present → flushD=flushE=1, stallF=0. Same case during MEM_WAIT → no flush until the release cycle.
- Reset mid-wait: drop rst_n in MEM_WAIT → all outputs 0 immediately; state RUN and stall_cycles 0 after release.
